// File: rtl/count_checker_if.sv
// count_checker_if: mismatch report valid/ready channel
interface count_checker_if #(parameter int WIDTH = 4);
  logic rpt_valid;
  logic rpt_ready;
  logic [WIDTH-1:0] rpt_expected;
  logic [WIDTH-1:0] rpt_actual;
  logic rpt_overrun;
  modport master(output rpt_valid, rpt_expected, rpt_actual, rpt_overrun, input rpt_ready);
  modport slave(input rpt_valid, rpt_expected, rpt_actual, rpt_overrun, output rpt_ready);
endinterface

// File: rtl/count_checker.sv
// count_checker: monitors an up-counter against a next-value model, counts errors and wraps
module count_checker #(
  parameter int WIDTH = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cnt_enable,
  input  logic [WIDTH-1:0]     cnt_out,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] wrap_count,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  count_checker_if.master      rpt
);
  typedef enum logic {SYNC, TRACK} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] prev_out, exp_val;
  logic prev_en, mismatch, wrap, load;
  // state register; reset always lands in SYNC
  always_ff @(posedge clk) state <= !rstn ? SYNC : state_nx;
  // next state, expected value, mismatch/wrap detection and report load decision
  always_comb begin
    state_nx = TRACK;
    exp_val = state == SYNC ? '0 : prev_out + WIDTH'(prev_en);
    mismatch = cnt_out != exp_val;
    wrap = state == TRACK && prev_out == '1 && prev_en && cnt_out == '0;
    load = mismatch && (!rpt.rpt_valid || rpt.rpt_ready);
  end
  // model reload from observed value, registered pulses, counters and report holding register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev_out <= '0;
      prev_en <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
      rpt.rpt_valid <= 1'b0;
      rpt.rpt_expected <= '0;
      rpt.rpt_actual <= '0;
      rpt.rpt_overrun <= 1'b0;
    end else begin
      prev_out <= cnt_out;
      prev_en <= cnt_enable;
      wrap_pulse <= wrap;
      wrap_count <= wrap_count + ERR_CNT_W'(wrap);
      err_pulse <= mismatch;
      err_count <= err_count + ERR_CNT_W'(mismatch && err_count != '1);
      rpt.rpt_valid <= load || (rpt.rpt_valid && !rpt.rpt_ready);
      rpt.rpt_overrun <= rpt.rpt_overrun || (mismatch && rpt.rpt_valid && !rpt.rpt_ready);
      if (load) begin
        rpt.rpt_expected <= exp_val;
        rpt.rpt_actual <= cnt_out;
      end
    end
  end
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: directed scenarios for count_checker with hand-computed expectations
module tb_count_checker;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cnt_enable = 1'b0;
  logic [3:0] cnt_out = '0;
  logic wrap_pulse, err_pulse;
  logic [7:0] wrap_count, err_count;
  logic [3:0] cnt = '0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int nerr, nwrap;
  count_checker_if #(.WIDTH(4)) rpt ();
  count_checker #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .cnt_enable(cnt_enable), .cnt_out(cnt_out),
    .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
    .err_pulse(err_pulse), .err_count(err_count), .rpt(rpt.master)
  );
  always #5 clk = ~clk;
  task automatic tick(input logic en, input logic [3:0] val);
    cnt_enable = en;
    cnt_out = val;
    @(posedge clk);
    #1;
    cnt = val + {3'b0, en};
  endtask
  task automatic run_to(input logic [3:0] t);
    for (int i = 0; i < 16 && cnt != t; i++) tick(1'b1, cnt);
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    rpt.rpt_ready = 1'b0;
    repeat (3) tick(1'b0, 4'd0);
    total_cnt++; if (err_count !== 8'd0) $display("FAIL reset_err_count got %0d want 0", err_count); else pass_cnt++;
    total_cnt++; if (wrap_count !== 8'd0) $display("FAIL reset_wrap_count got %0d want 0", wrap_count); else pass_cnt++;
    total_cnt++; if ({err_pulse, wrap_pulse} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {err_pulse, wrap_pulse}); else pass_cnt++;
    total_cnt++; if ({rpt.rpt_valid, rpt.rpt_overrun} !== 2'b00) $display("FAIL reset_rpt_flags got %b want 00", {rpt.rpt_valid, rpt.rpt_overrun}); else pass_cnt++;
    total_cnt++; if ({rpt.rpt_expected, rpt.rpt_actual} !== 8'h00) $display("FAIL reset_rpt_data got %h want 00", {rpt.rpt_expected, rpt.rpt_actual}); else pass_cnt++;
    rstn = 1'b1;
    cnt = 4'd0;
  endtask
  task automatic test_wrap;
    nerr = 0;
    nwrap = 0;
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, cnt);
      nerr += int'(err_pulse);
      nwrap += int'(wrap_pulse);
      if (i == 16) begin
        total_cnt++; if (wrap_pulse !== 1'b1) $display("FAIL wrap_pulse_at_0 got %b want 1", wrap_pulse); else pass_cnt++;
      end
    end
    total_cnt++; if (nerr !== 0) $display("FAIL wrap_no_err got %0d want 0", nerr); else pass_cnt++;
    total_cnt++; if (nwrap !== 1) $display("FAIL wrap_pulse_count got %0d want 1", nwrap); else pass_cnt++;
    total_cnt++; if (wrap_count !== 8'd1) $display("FAIL wrap_count got %0d want 1", wrap_count); else pass_cnt++;
    total_cnt++; if (err_count !== 8'd0) $display("FAIL wrap_err_count got %0d want 0", err_count); else pass_cnt++;
  endtask
  task automatic test_enable_toggle;
    run_to(4'd5);
    nerr = 0;
    tick(1'b1, 4'd5); nerr += int'(err_pulse);
    tick(1'b0, 4'd6); nerr += int'(err_pulse);
    tick(1'b0, 4'd6); nerr += int'(err_pulse);
    tick(1'b1, 4'd6); nerr += int'(err_pulse);
    tick(1'b1, 4'd7); nerr += int'(err_pulse);
    total_cnt++; if (nerr !== 0) $display("FAIL toggle_no_err got %0d want 0", nerr); else pass_cnt++;
    total_cnt++; if (err_count !== 8'd0) $display("FAIL toggle_err_count got %0d want 0", err_count); else pass_cnt++;
  endtask
  task automatic test_mismatch;
    rpt.rpt_ready = 1'b1;
    run_to(4'd3);
    tick(1'b1, 4'd3);
    tick(1'b1, 4'd9);
    total_cnt++; if (err_pulse !== 1'b1) $display("FAIL mm_err_pulse got %b want 1", err_pulse); else pass_cnt++;
    total_cnt++; if (rpt.rpt_valid !== 1'b1) $display("FAIL mm_rpt_valid got %b want 1", rpt.rpt_valid); else pass_cnt++;
    total_cnt++; if (rpt.rpt_expected !== 4'd4) $display("FAIL mm_expected got %0d want 4", rpt.rpt_expected); else pass_cnt++;
    total_cnt++; if (rpt.rpt_actual !== 4'd9) $display("FAIL mm_actual got %0d want 9", rpt.rpt_actual); else pass_cnt++;
    total_cnt++; if (err_count !== 8'd1) $display("FAIL mm_err_count got %0d want 1", err_count); else pass_cnt++;
    total_cnt++; if (wrap_count !== 8'd2) $display("FAIL mm_wrap_count got %0d want 2", wrap_count); else pass_cnt++;
    tick(1'b1, 4'd10);
    total_cnt++; if (err_pulse !== 1'b0) $display("FAIL mm_resync_10 got %b want 0", err_pulse); else pass_cnt++;
    total_cnt++; if (rpt.rpt_valid !== 1'b0) $display("FAIL mm_consumed got %b want 0", rpt.rpt_valid); else pass_cnt++;
    tick(1'b1, 4'd11);
    total_cnt++; if (err_pulse !== 1'b0) $display("FAIL mm_resync_11 got %b want 0", err_pulse); else pass_cnt++;
    total_cnt++; if (err_count !== 8'd1) $display("FAIL mm_err_count_hold got %0d want 1", err_count); else pass_cnt++;
  endtask
  task automatic test_overrun;
    rpt.rpt_ready = 1'b0;
    run_to(4'd2);
    tick(1'b1, 4'd2);
    tick(1'b1, 4'd7);
    total_cnt++; if ({err_pulse, rpt.rpt_valid, rpt.rpt_overrun} !== 3'b110) $display("FAIL ov_first got %b want 110", {err_pulse, rpt.rpt_valid, rpt.rpt_overrun}); else pass_cnt++;
    tick(1'b1, 4'd2);
    total_cnt++; if (err_pulse !== 1'b1) $display("FAIL ov_second_pulse got %b want 1", err_pulse); else pass_cnt++;
    total_cnt++; if ({rpt.rpt_expected, rpt.rpt_actual} !== 8'h37) $display("FAIL ov_report_held got %h want 37", {rpt.rpt_expected, rpt.rpt_actual}); else pass_cnt++;
    total_cnt++; if (rpt.rpt_overrun !== 1'b1) $display("FAIL ov_overrun got %b want 1", rpt.rpt_overrun); else pass_cnt++;
    total_cnt++; if (err_count !== 8'd3) $display("FAIL ov_err_count got %0d want 3", err_count); else pass_cnt++;
    total_cnt++; if (wrap_count !== 8'd3) $display("FAIL ov_wrap_count got %0d want 3", wrap_count); else pass_cnt++;
    tick(1'b1, 4'd3);
    total_cnt++; if ({rpt.rpt_valid, rpt.rpt_expected, rpt.rpt_actual} !== 9'h137) $display("FAIL ov_stable got %h want 137", {rpt.rpt_valid, rpt.rpt_expected, rpt.rpt_actual}); else pass_cnt++;
    rpt.rpt_ready = 1'b1;
    tick(1'b1, 4'd4);
    total_cnt++; if ({rpt.rpt_valid, err_pulse} !== 2'b00) $display("FAIL ov_drain got %b want 00", {rpt.rpt_valid, err_pulse}); else pass_cnt++;
    total_cnt++; if (rpt.rpt_overrun !== 1'b1) $display("FAIL ov_sticky got %b want 1", rpt.rpt_overrun); else pass_cnt++;
  endtask
  task automatic test_saturate;
    rpt.rpt_ready = 1'b1;
    repeat (252) tick(1'b1, cnt + 4'd1);
    total_cnt++; if (err_count !== 8'd255) $display("FAIL sat_reach got %0d want 255", err_count); else pass_cnt++;
    repeat (7) tick(1'b1, cnt + 4'd1);
    total_cnt++; if (err_count !== 8'd255) $display("FAIL sat_hold got %0d want 255", err_count); else pass_cnt++;
    total_cnt++; if (err_pulse !== 1'b1) $display("FAIL sat_pulse got %b want 1", err_pulse); else pass_cnt++;
    total_cnt++; if (wrap_count !== 8'd3) $display("FAIL sat_no_wrap got %0d want 3", wrap_count); else pass_cnt++;
    tick(1'b1, cnt);
    total_cnt++; if ({err_pulse, err_count} !== 9'h0ff) $display("FAIL sat_clean got %h want 0ff", {err_pulse, err_count}); else pass_cnt++;
  endtask
  task automatic test_reset_mid;
    run_to(4'd10);
    rpt.rpt_ready = 1'b0;
    tick(1'b1, 4'd3);
    total_cnt++; if (rpt.rpt_valid !== 1'b1) $display("FAIL rm_pending got %b want 1", rpt.rpt_valid); else pass_cnt++;
    run_to(4'd12);
    rstn = 1'b0;
    tick(1'b1, 4'd12);
    total_cnt++; if ({err_count, wrap_count} !== 16'h0000) $display("FAIL rm_counts got %h want 0000", {err_count, wrap_count}); else pass_cnt++;
    total_cnt++; if ({err_pulse, wrap_pulse, rpt.rpt_valid, rpt.rpt_overrun} !== 4'b0000) $display("FAIL rm_flags got %b want 0000", {err_pulse, wrap_pulse, rpt.rpt_valid, rpt.rpt_overrun}); else pass_cnt++;
    total_cnt++; if ({rpt.rpt_expected, rpt.rpt_actual} !== 8'h00) $display("FAIL rm_rpt_data got %h want 00", {rpt.rpt_expected, rpt.rpt_actual}); else pass_cnt++;
    rstn = 1'b1;
    cnt = 4'd0;
    nerr = 0;
    repeat (5) begin
      tick(1'b1, cnt);
      nerr += int'(err_pulse);
    end
    total_cnt++; if (nerr !== 0) $display("FAIL rm_restart_err got %0d want 0", nerr); else pass_cnt++;
    total_cnt++; if ({err_count, rpt.rpt_valid} !== 9'h000) $display("FAIL rm_restart_state got %h want 000", {err_count, rpt.rpt_valid}); else pass_cnt++;
  endtask
  initial begin
    rpt.rpt_ready = 1'b0;
    test_reset;
    test_wrap;
    test_enable_toggle;
    test_mismatch;
    test_overrun;
    test_saturate;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
